// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP state encoding, opcodes and IR capture pattern
// Contents:
//   tap_state_t  4-bit IEEE 1149.1 TAP state encoding
//   BYPASS       all-ones opcode (truncated to the IR width by the user)
//   IDCODE       identification register opcode
//   USERCODE     user code register opcode (decoded only with JTAG_USERCODE_EN)
//   IR_CAPTURE   low two bits loaded into the IR shifter in Capture-IR
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  localparam logic [31:0] BYPASS   = 32'hFFFF_FFFF;
  localparam logic [31:0] IDCODE   = 32'h0000_0001;
  localparam logic [31:0] USERCODE = 32'h0000_0003;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// rtl/tap_fsm.sv - 16-state TAP state register and next-state logic
// Ports:
//   i_tck     test clock, state advances on its rising edge
//   i_trst_n  asynchronous active-low reset to Test-Logic-Reset
//   i_tms     mode select
//   o_state   current TAP state
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst_n,
  input  logic       i_tms,
  output tap_state_t o_state
);

  tap_state_t r_state;
  tap_state_t w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:      w_next = i_tms ? TLR      : RTI;
      RTI:      w_next = i_tms ? SEL_DR   : RTI;
      SEL_DR:   w_next = i_tms ? SEL_IR   : CAP_DR;
      CAP_DR:   w_next = i_tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: w_next = i_tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: w_next = i_tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: w_next = i_tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: w_next = i_tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   w_next = i_tms ? SEL_DR   : RTI;
      SEL_IR:   w_next = i_tms ? TLR      : CAP_IR;
      CAP_IR:   w_next = i_tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: w_next = i_tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: w_next = i_tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: w_next = i_tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: w_next = i_tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   w_next = i_tms ? SEL_DR   : RTI;
      default:  w_next = TLR;
    endcase
  end

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      r_state <= TLR;
    end else begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - IEEE 1149.1 TAP controller with IR, bypass and DR controls
// Optional feature macro: JTAG_USERCODE_EN (adds usercode_tdo and the USERCODE opcode)
// Ports:
//   tck                 test clock
//   trst                asynchronous active-low reset
//   tms                 mode select, sampled on rising tck
//   tdi                 serial in (IR shifter, bypass register)
//   id_tdo              serial out of the identification register
//   usercode_tdo        serial out of the user code register (JTAG_USERCODE_EN only)
//   tdo / tdo_en        serial out and pad enable, both launched on falling tck
//   clockDR             gated tck for data registers (Capture-DR, Shift-DR)
//   captureDR/shiftDR   state decodes for data registers
//   updateDR            high during the low phase of tck in Update-DR
//   test_logic_reset_n  low while in Test-Logic-Reset
//   instr               current instruction
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = 4
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  input  logic                id_tdo,
`ifdef JTAG_USERCODE_EN
  input  logic                usercode_tdo,
`endif
  output logic                tdo,
  output logic                tdo_en,
  output logic                clockDR,
  output logic                captureDR,
  output logic                shiftDR,
  output logic                updateDR,
  output logic                test_logic_reset_n,
  output logic [IR_WIDTH-1:0] instr
);

  localparam logic [IR_WIDTH-1:0] L_IDCODE     = IDCODE[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] L_IR_CAPTURE = IR_WIDTH'(IR_CAPTURE);
`ifdef JTAG_USERCODE_EN
  localparam logic [IR_WIDTH-1:0] L_USERCODE   = USERCODE[IR_WIDTH-1:0];
`endif

  tap_state_t          w_state;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [IR_WIDTH-1:0] r_instr;
  logic                r_bypass;
  logic                r_tdo;
  logic                r_tdo_en;
  logic                r_dr_clk_en;
  logic                r_tlr_n;
  logic                r_upd_dr;
  logic                w_tdo_next;
  logic                w_sel_idcode;
`ifdef JTAG_USERCODE_EN
  logic                w_sel_usercode;
`endif

  tap_fsm u_tap_fsm (
    .i_tck    (tck),
    .i_trst_n (trst),
    .i_tms    (tms),
    .o_state  (w_state)
  );

  // IR shifter: capture pattern lets a host check IR chain length and integrity
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_ir_shift <= '0;
    end else if (w_state == CAP_IR) begin
      r_ir_shift <= L_IR_CAPTURE;
    end else if (w_state == SHIFT_IR) begin
      r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
    end
  end

  // Instruction changes on falling tck so it is stable across the next rising edge
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      r_instr <= L_IDCODE;
    end else if (w_state == TLR) begin
      r_instr <= L_IDCODE;
    end else if (w_state == UPD_IR) begin
      r_instr <= r_ir_shift;
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_bypass <= 1'b0;
    end else if (w_state == CAP_DR) begin
      r_bypass <= 1'b0;
    end else if (w_state == SHIFT_DR) begin
      r_bypass <= tdi;
    end
  end

  // Unknown opcodes fall through to the bypass bit
  assign w_sel_idcode = (r_instr == L_IDCODE);
`ifdef JTAG_USERCODE_EN
  assign w_sel_usercode = (r_instr == L_USERCODE);
`endif

  always_comb begin
    w_tdo_next = 1'b0;
    if (w_state == SHIFT_IR) begin
      w_tdo_next = r_ir_shift[0];
    end else if (w_state == SHIFT_DR) begin
      if (w_sel_idcode) begin
        w_tdo_next = id_tdo;
`ifdef JTAG_USERCODE_EN
      end else if (w_sel_usercode) begin
        w_tdo_next = usercode_tdo;
`endif
      end else begin
        w_tdo_next = r_bypass;
      end
    end
  end

  // Falling-edge outputs: tdo retiming, pad enable, DR clock gate, reset flag, update strobe
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      r_tdo       <= 1'b0;
      r_tdo_en    <= 1'b0;
      r_dr_clk_en <= 1'b0;
      r_tlr_n     <= 1'b0;
      r_upd_dr    <= 1'b0;
    end else begin
      r_tdo       <= w_tdo_next;
      r_tdo_en    <= (w_state == SHIFT_IR) || (w_state == SHIFT_DR);
      r_dr_clk_en <= (w_state == CAP_DR) || (w_state == SHIFT_DR);
      r_tlr_n     <= (w_state != TLR);
      r_upd_dr    <= (w_state == UPD_DR);
    end
  end

  // Enable only changes while tck is low, so the AND cannot chop a high phase
  assign clockDR            = tck & r_dr_clk_en;
  assign updateDR           = r_upd_dr & ~tck;
  assign captureDR          = (w_state == CAP_DR);
  assign shiftDR            = (w_state == SHIFT_DR);
  assign tdo                = r_tdo;
  assign tdo_en             = r_tdo_en;
  assign test_logic_reset_n = r_tlr_n;
  assign instr              = r_instr;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb/tb_jtag_tap_controller.sv - self-checking bench for jtag_tap_controller
module tb_jtag_tap_controller;

  localparam int          IRW    = 4;
  localparam logic [31:0] ID_VAL = 32'h1234_5679;
  localparam logic [31:0] UC_VAL = 32'hC0DE_A5E1;

  logic           tck = 1'b0;
  logic           trst = 1'b1;
  logic           tms = 1'b1;
  logic           tdi = 1'b0;
  logic           id_tdo;
  logic           usercode_tdo;
  logic           tdo, tdo_en, clockDR, captureDR, shiftDR, updateDR, test_logic_reset_n;
  logic [IRW-1:0] instr;

  jtag_tap_controller #(.IR_WIDTH(IRW)) dut (
    .tck                (tck),
    .trst               (trst),
    .tms                (tms),
    .tdi                (tdi),
    .id_tdo             (id_tdo),
`ifdef JTAG_USERCODE_EN
    .usercode_tdo       (usercode_tdo),
`endif
    .tdo                (tdo),
    .tdo_en             (tdo_en),
    .clockDR            (clockDR),
    .captureDR          (captureDR),
    .shiftDR            (shiftDR),
    .updateDR           (updateDR),
    .test_logic_reset_n (test_logic_reset_n),
    .instr              (instr)
  );

  always #10 tck = ~tck;

  // Data register models (ID and user code), driven from the decoded DR phase
  logic [31:0] idreg = '0;
  logic [31:0] ucreg = '0;
  logic        m_cap = 1'b0;
  logic        m_shift = 1'b0;
  int          pulse_cnt = 0;
  int          cap_hits = 0;
  int          cap_at = -1;

  assign id_tdo       = idreg[0];
  assign usercode_tdo = ucreg[0];

  always @(negedge tck) begin
    m_cap   <= captureDR;
    m_shift <= shiftDR;
  end

  always @(posedge tck) begin
    if (m_cap) begin
      idreg <= ID_VAL;
      ucreg <= UC_VAL;
    end else if (m_shift) begin
      idreg <= {tdi, idreg[31:1]};
      ucreg <= {tdi, ucreg[31:1]};
    end
  end

  always @(posedge tck) begin
    #1;
    if (clockDR) begin
      if (m_cap) begin
        cap_hits++;
        cap_at = pulse_cnt;
      end
      pulse_cnt++;
    end
  end

  int   n_vec = 0;
  int   n_bad = 0;
  logic exp_q[$];

  typedef struct {
    logic tms;
    logic cap;
    logic sh;
    logic en;
    logic tlrn;
    logic upd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic sb_tdo(input string name, input int idx);
    logic e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s[%0d]: scoreboard empty, tdo=%0b", name, idx, tdo);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", name, idx), {31'b0, tdo}, {31'b0, e});
    end
  endtask

  // Entered at negedge+2; leaves at the next negedge+2
  task automatic step(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge tck);
    @(negedge tck);
    #2;
  endtask

  // From a Capture state: enter Shift, run n shift edges (last exits), compare tdo
  task automatic shift_seq(input int n, input logic [63:0] bits, input string name);
    step(1'b0, 1'b0);
    sb_tdo(name, 0);
    for (int k = 0; k < n; k++) begin
      step(k == n - 1, bits[k]);
      if (k < n - 1) sb_tdo(name, k + 1);
    end
  endtask

  task automatic load_ir(input logic [IRW-1:0] val);
    logic [IRW-1:0] cap;
    cap = IRW'(2'b01);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < IRW; i++) exp_q.push_back(cap[i]);
    shift_seq(IRW, 64'(val), "ir_capture");
    step(1'b1, 1'b0);
    chk("instr_after_update", 32'(instr), 32'(val));
    step(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] bits, input string name);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    shift_seq(n, bits, name);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] bits;
    int          p0, c0;

    //                tms   cap   sh    en    tlrn  upd    (state reached)
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // RTI
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // SelDR
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}); // CapDR
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}); // ShiftDR
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}); // ShiftDR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // Exit1DR
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // PauseDR
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // PauseDR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // Exit2DR
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}); // ShiftDR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // Exit1DR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}); // UpdDR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // SelDR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // SelIR
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // CapIR
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}); // ShiftIR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // Exit1IR
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // PauseIR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // Exit2IR
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}); // ShiftIR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // Exit1IR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // UpdIR
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // RTI
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // SelDR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // SelIR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}); // TLR
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}); // TLR

    // Reset values
    #3 trst = 1'b0;
    #30;
    chk("rst_tdo",      32'(tdo), 32'd0);
    chk("rst_tdo_en",   32'(tdo_en), 32'd0);
    chk("rst_tlr_n",    32'(test_logic_reset_n), 32'd0);
    chk("rst_clockDR",  32'(clockDR), 32'd0);
    chk("rst_updateDR", 32'(updateDR), 32'd0);
    chk("rst_instr",    32'(instr), 32'd1);
    @(negedge tck);
    #2 trst = 1'b1;

    step(1'b0, 1'b0);
    chk("rti_instr",  32'(instr), 32'd1);
    chk("rti_tlr_n",  32'(test_logic_reset_n), 32'd1);
    chk("rti_tdo_en", 32'(tdo_en), 32'd0);

    // FSM walk from RTI through both columns back to TLR
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].tms, 1'b0);
      chk($sformatf("walk%0d_captureDR", i), 32'(captureDR), 32'(tbl[i].cap));
      chk($sformatf("walk%0d_shiftDR", i),   32'(shiftDR), 32'(tbl[i].sh));
      chk($sformatf("walk%0d_tdo_en", i),    32'(tdo_en), 32'(tbl[i].en));
      chk($sformatf("walk%0d_tlr_n", i),     32'(test_logic_reset_n), 32'(tbl[i].tlrn));
      chk($sformatf("walk%0d_updateDR", i),  32'(updateDR), 32'(tbl[i].upd));
    end
    chk("walk_instr_tlr", 32'(instr), 32'd1);

    // IDCODE scan: 32 bits LSB first, 33 clockDR pulses, capture on the first only
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    p0 = pulse_cnt;
    c0 = cap_hits;
    for (int i = 0; i < 32; i++) exp_q.push_back(ID_VAL[i]);
    shift_seq(32, 64'd0, "idcode");
    chk("idcode_clockDR_pulses", 32'(pulse_cnt - p0), 32'd33);
    chk("idcode_capture_pulses", 32'(cap_hits - c0), 32'd1);
    chk("idcode_capture_first",  32'(cap_at), 32'(p0));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // BYPASS: tdo follows tdi one tck late, first bit 0
    load_ir(4'b1111);
    bits = 64'h0000_0000_0000_00B2;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_q.push_back(bits[i]);
    dr_scan(8, bits, "bypass");

    // Undefined opcode behaves as bypass
    load_ir(4'b0110);
    bits = 64'h0000_0000_0000_005D;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_q.push_back(bits[i]);
    dr_scan(8, bits, "undef_bypass");

    // USERCODE opcode
    load_ir(4'b0011);
    bits = {32'd0, $urandom()};
`ifdef JTAG_USERCODE_EN
    for (int i = 0; i < 32; i++) exp_q.push_back(UC_VAL[i]);
`else
    exp_q.push_back(1'b0);
    for (int i = 0; i < 31; i++) exp_q.push_back(bits[i]);
`endif
    dr_scan(32, bits, "usercode");

    // From Pause-DR, five tms=1 edges reach TLR
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("pause_tlr_n", 32'(test_logic_reset_n), 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("pause_upd_strobe", 32'(updateDR), 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("pause_not_yet_tlr", 32'(test_logic_reset_n), 32'd1);
    step(1'b1, 1'b0);
    chk("pause5_tlr_n", 32'(test_logic_reset_n), 32'd0);
    chk("pause5_instr", 32'(instr), 32'd1);

    // trst during Shift-IR after two bits
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("trst_pre_tdo_en", 32'(tdo_en), 32'd1);
    trst = 1'b0;
    #1;
    chk("trst_tdo_en", 32'(tdo_en), 32'd0);
    chk("trst_instr",  32'(instr), 32'd1);
    chk("trst_tlr_n",  32'(test_logic_reset_n), 32'd0);
    #3 trst = 1'b1;
    step(1'b0, 1'b0);
    chk("post_trst_instr",  32'(instr), 32'd1);
    chk("post_trst_tlr_n",  32'(test_logic_reset_n), 32'd1);
    chk("post_trst_tdo_en", 32'(tdo_en), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
